// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UartTx: per-requester FIFOs with valid/ready push,
// and an FSM that issues one tx_start per byte. Optional macro: UART_TX_ARB_ROUND_ROBIN_EN.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] sdata,
  output logic       grant,
  output logic       idle
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_GUARD, S_WAIT} state_t;

  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  state_t             state_q, state_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         sdata_q, sdata_d;
  logic               grant_q, grant_d;

  logic [7:0]         mem_q      [2][FIFO_DEPTH];
  logic [7:0]         mem_d      [2][FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q   [2];
  logic [FIFO_AW-1:0] wr_ptr_d   [2];
  logic [FIFO_AW-1:0] rd_ptr_q   [2];
  logic [FIFO_AW-1:0] rd_ptr_d   [2];
  logic [FIFO_AW:0]   count_q    [2];
  logic [FIFO_AW:0]   count_d    [2];

  logic [1:0]         req_valid;
  logic [7:0]         req_data   [2];
  logic [1:0]         empty, full, ready, push, pop;
  logic               sel;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // Ready comes from the registered count only, so a pop on a full FIFO frees a slot one cycle later.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == FULL_CNT);
      ready[i] = !full[i] && !reset;
      push[i]  = req_valid[i] && ready[i];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    sel = empty[0];
    if (!empty[0] && !empty[1]) begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
      sel = ~grant_q;
`else
      sel = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    sdata_d    = sdata_q;
    grant_d    = grant_q;
    pop        = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && (empty != 2'b11)) begin
          pop[sel]   = 1'b1;
          sdata_d    = mem_q[sel][rd_ptr_q[sel]];
          grant_d    = sel;
          tx_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: state_d = S_GUARD;
      // UartTx raises busy one cycle late, so busy is not trusted until WAIT.
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) mem_d[i][j] = mem_q[i][j];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = req_data[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + 1'b1;
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= mem_d[i][j];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      sdata_q    <= 8'h00;
      grant_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      sdata_q    <= sdata_d;
      grant_q    <= grant_d;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  assign tx_start = tx_start_q;
  assign sdata    = sdata_q;
  assign grant    = grant_q;
  assign idle     = (state_q == S_IDLE) && (empty == 2'b11);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UartTx busy model.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] sdata;
  logic       grant;
  logic       idle;

  int checks = 0;
  int passes = 0;

  logic       force_busy = 1'b0;
  int         model_len = 3;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         start_while_busy = 0;
  logic [7:0] log_data[$];
  logic       log_grant[$];
  int         log_cyc[$];

  uart_tx_arbiter #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .sdata(sdata), .grant(grant), .idle(idle)
  );

  always #5 clock = ~clock;

  // UartTx stand-in: busy rises on the edge that samples tx_start and lasts model_len cycles.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) busy_cnt <= 0;
    else if (tx_start && model_len > 0) busy_cnt <= model_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = force_busy | (busy_cnt != 0);

  always @(posedge clock) begin
    if (!reset && tx_start) begin
      log_data.push_back(sdata);
      log_grant.push_back(grant);
      log_cyc.push_back(cyc);
      if (tx_busy) start_while_busy <= start_while_busy + 1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (log_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (idle) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic push_blocking(input bit which, input logic [7:0] data);
    if (which) begin req1_valid = 1'b1; req1_data = data; end
    else       begin req0_valid = 1'b1; req0_data = data; end
    for (int i = 0; i < 50; i++) begin
      if ((which ? req1_ready : req0_ready) == 1'b1) break;
      tick();
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({req0_ready, req1_ready, tx_start, sdata, grant, idle} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1})
      $display("[TB] FAIL reset_values: got r0=%b r1=%b start=%b sdata=%h grant=%b idle=%b, want 0 0 0 00 0 1",
               req0_ready, req1_ready, tx_start, sdata, grant, idle);
    else passes++;
    reset = 1'b0;
    tick();
    checks++;
    if ({req0_ready, req1_ready, idle} !== 3'b111)
      $display("[TB] FAIL after_reset: got r0=%b r1=%b idle=%b, want 1 1 1", req0_ready, req1_ready, idle);
    else passes++;
  endtask

  task automatic test_single_byte;
    bit ok;
    int n0;
    model_len = 3;
    n0 = log_data.size();
    req0_data = 8'h55;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    checks++;
    if (tx_start !== 1'b0) $display("[TB] FAIL single_early: tx_start=%b, want 0", tx_start);
    else passes++;
    tick();
    checks++;
    if ({tx_start, sdata, grant} !== {1'b1, 8'h55, 1'b0})
      $display("[TB] FAIL single_start: got start=%b sdata=%h grant=%b, want 1 55 0", tx_start, sdata, grant);
    else passes++;
    tick();
    checks++;
    if (tx_start !== 1'b0) $display("[TB] FAIL single_pulse_width: tx_start=%b, want 0", tx_start);
    else passes++;
    wait_idle(50, ok);
    checks++;
    if (!ok || log_data.size() != n0 + 1)
      $display("[TB] FAIL single_idle: idle=%b starts=%0d, want 1 and %0d", idle, log_data.size() - n0, 1);
    else passes++;
  endtask

  task automatic test_backpressure;
    bit ok;
    bit accepted;
    int n0;
    force_busy = 1'b1;
    model_len = 3;
    n0 = log_data.size();
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1'b1;
      req1_data = 8'(i + 1);
      checks++;
      if (req1_ready !== 1'b1) $display("[TB] FAIL bp_accept_%0d: ready=%b, want 1", i, req1_ready);
      else passes++;
      tick();
    end
    req1_data = 8'h05;
    checks++;
    if (req1_ready !== 1'b0) $display("[TB] FAIL bp_full: ready=%b, want 0", req1_ready);
    else passes++;
    repeat (5) tick();
    checks++;
    if (req1_ready !== 1'b0 || log_data.size() != n0)
      $display("[TB] FAIL bp_hold: ready=%b starts=%0d, want 0 and 0", req1_ready, log_data.size() - n0);
    else passes++;
    force_busy = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req1_ready) begin
        accepted = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req1_valid = 1'b0;
    checks++;
    if (!accepted) $display("[TB] FAIL bp_fifth_accept: ready never rose, want 1");
    else passes++;
    wait_log(n0 + 5, 200, ok);
    checks++;
    if (!ok) $display("[TB] FAIL bp_drain: starts=%0d, want 5", log_data.size() - n0);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      if (n0 + i < log_data.size()) begin
        checks++;
        if ({log_data[n0+i], log_grant[n0+i]} !== {8'(i + 1), 1'b1})
          $display("[TB] FAIL bp_order_%0d: got %h/g%b, want %h/g1", i, log_data[n0+i], log_grant[n0+i], 8'(i + 1));
        else passes++;
      end
    end
    wait_idle(100, ok);
  endtask

  task automatic test_contention;
    bit ok;
    int n0;
    logic [7:0] exp_d [3];
    logic       exp_g [3];
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
    exp_d = '{8'hB0, 8'hA0, 8'hA1};
    exp_g = '{1'b1, 1'b0, 1'b0};
`else
    exp_d = '{8'hA0, 8'hA1, 8'hB0};
    exp_g = '{1'b0, 1'b0, 1'b1};
`endif
    do_reset();
    force_busy = 1'b1;
    n0 = log_data.size();
    push_blocking(1'b0, 8'hA0);
    push_blocking(1'b0, 8'hA1);
    push_blocking(1'b1, 8'hB0);
    force_busy = 1'b0;
    wait_log(n0 + 3, 200, ok);
    checks++;
    if (!ok) $display("[TB] FAIL cont_drain: starts=%0d, want 3", log_data.size() - n0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      if (n0 + i < log_data.size()) begin
        checks++;
        if ({log_data[n0+i], log_grant[n0+i]} !== {exp_d[i], exp_g[i]})
          $display("[TB] FAIL cont_order_%0d: got %h/g%b, want %h/g%b",
                   i, log_data[n0+i], log_grant[n0+i], exp_d[i], exp_g[i]);
        else passes++;
      end
    end
    wait_idle(100, ok);
  endtask

  task automatic test_busy_timing;
    bit ok;
    int n0;
    model_len = 20;
    force_busy = 1'b1;
    n0 = log_data.size();
    push_blocking(1'b0, 8'hC1);
    push_blocking(1'b0, 8'hC2);
    force_busy = 1'b0;
    wait_log(n0 + 2, 200, ok);
    repeat (40) tick();
    checks++;
    if (!ok || log_data.size() != n0 + 2)
      $display("[TB] FAIL busy_count: starts=%0d, want 2", log_data.size() - n0);
    else passes++;
    if (log_data.size() >= n0 + 2) begin
      checks++;
      if (log_cyc[n0+1] - log_cyc[n0] != 23)
        $display("[TB] FAIL busy_spacing: got %0d cycles, want 23", log_cyc[n0+1] - log_cyc[n0]);
      else passes++;
    end
    checks++;
    if (start_while_busy != 0) $display("[TB] FAIL start_while_busy: got %0d, want 0", start_while_busy);
    else passes++;
    model_len = 3;
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int n0;
    model_len = 20;
    force_busy = 1'b1;
    n0 = log_data.size();
    push_blocking(1'b0, 8'hD1);
    push_blocking(1'b0, 8'hD2);
    push_blocking(1'b1, 8'hD3);
    force_busy = 1'b0;
    wait_log(n0 + 1, 50, ok);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("[TB] FAIL rst_ready: got r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
    else passes++;
    tick();
    checks++;
    if ({tx_start, sdata, idle} !== {1'b0, 8'h00, 1'b1})
      $display("[TB] FAIL rst_mid: got start=%b sdata=%h idle=%b, want 0 00 1", tx_start, sdata, idle);
    else passes++;
    reset = 1'b0;
    model_len = 3;
    n0 = log_data.size();
    repeat (30) tick();
    checks++;
    if (log_data.size() != n0) $display("[TB] FAIL rst_stale: starts=%0d, want 0", log_data.size() - n0);
    else passes++;
    push_blocking(1'b0, 8'h7E);
    wait_log(n0 + 1, 50, ok);
    checks++;
    if (!ok || log_data[n0] !== 8'h7E || log_grant[n0] !== 1'b0)
      $display("[TB] FAIL rst_fresh: starts=%0d, want 0x7E on grant 0", log_data.size() - n0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_contention();
    test_busy_timing();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
